// File: rtl/iddmm_div_256_by_128.sv
// Sequential radix-2 restoring divider: DW-bit dividend / VW-bit divisor, one quotient bit per clock.
// Operands enter over a valid/ready pair; results are held in DONE until the consumer takes them.
module iddmm_div_256_by_128 #(
  parameter int DW = 256,
  parameter int VW = 128,
  parameter int CW = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // CALC  | shifting one dividend bit per clock, MSB first
  // DONE  | results valid, waiting for out_ready
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t r_state;
  state_t w_next;

  logic [DW-1:0] r_shift;
  logic [VW-1:0] r_div;
  logic [VW-1:0] r_rem;
  logic [DW-1:0] r_quo;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_q_out;
  logic [VW-1:0] r_r_out;
  logic          r_dbz;

  logic          w_accept;
  logic          w_last;
  logic          w_div_zero;
  logic [VW:0]   w_rp;
  logic          w_ge;
  logic [VW-1:0] w_rn;
  logic [DW-1:0] w_qn;

  assign w_accept   = in_valid && in_ready;
  assign w_last     = (r_cnt == CW'(DW - 1));
  assign w_div_zero = (divisor == '0);

  // The shifted partial remainder needs VW+1 bits; since r < divisor always holds,
  // the stored remainder fits back into VW bits after the conditional subtract.
  assign w_rp = {r_rem, r_shift[DW-1]};
  assign w_ge = (w_rp >= {1'b0, r_div});
  assign w_rn = w_ge ? VW'(w_rp - {1'b0, r_div}) : w_rp[VW-1:0];
  assign w_qn = {r_quo[DW-2:0], w_ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_next = w_div_zero ? DONE : CALC;
      CALC: if (w_last)   w_next = DONE;
      DONE: if (out_ready) w_next = IDLE;
      default:            w_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (r_state == IDLE);
    out_valid = (r_state == DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shift <= '0;
      r_div   <= '0;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      r_q_out <= '0;
      r_r_out <= '0;
      r_dbz   <= 1'b0;
    end else if (w_accept) begin
      r_shift <= dividend;
      r_div   <= divisor;
      r_rem   <= '0;
      r_quo   <= '0;
      r_cnt   <= '0;
      if (w_div_zero) begin
        r_q_out <= '1;
        r_r_out <= dividend[VW-1:0];
        r_dbz   <= 1'b1;
      end
    end else if (r_state == CALC) begin
      r_shift <= {r_shift[DW-2:0], 1'b0};
      r_rem   <= w_rn;
      r_quo   <= w_qn;
      r_cnt   <= r_cnt + 1'b1;
      if (w_last) begin
        r_q_out <= w_qn;
        r_r_out <= w_rn;
        r_dbz   <= 1'b0;
      end
    end
  end

  assign quotient    = r_q_out;
  assign remainder   = r_r_out;
  assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_iddmm_div_256_by_128.sv
// Bench for iddmm_div_256_by_128: reference quotient/remainder from plain wide division,
// a per-cycle compare process while out_valid is high, directed corner cases plus random operands.
module tb_iddmm_div_256_by_128;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [255:0] dividend = '0;
  logic [127:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [255:0] quotient;
  logic [127:0] remainder;
  logic         div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  logic [255:0] exp_q;
  logic [127:0] exp_r;
  logic         exp_z;
  bit           exp_valid = 1'b0;

  iddmm_div_256_by_128 dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor), .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: unsigned division in plain arithmetic.
  task automatic model(input logic [255:0] a, input logic [127:0] b);
    logic [255:0] bw;
    bw = {128'b0, b};
    if (b == '0) begin
      exp_q = '1;
      exp_r = a[127:0];
      exp_z = 1'b1;
    end else begin
      exp_q = a / bw;
      exp_r = 128'(a % bw);
      exp_z = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      if (!exp_valid) begin
        check("stale_out_valid", 256'(out_valid), 256'(0));
      end else begin
        check("quotient", quotient, exp_q);
        check("remainder", 256'(remainder), 256'(exp_r));
        check("div_by_zero", 256'(div_by_zero), 256'(exp_z));
        check("in_ready_in_done", 256'(in_ready), 256'(0));
      end
    end
  end

  function automatic logic [255:0] rnd256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic do_op(input logic [255:0] a, input logic [127:0] b, input int hold, input bit noise);
    int lat;
    int guard;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("in_ready_timeout", 256'(in_ready), 256'(1));
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    model(a, b);
    exp_valid = 1'b1;
    in_valid = 1'b0;
    dividend = rnd256();
    divisor  = 128'(rnd256());
    lat = 0;
    while (lat < 400) begin
      if (noise) begin
        in_valid = 1'b1;
        dividend = rnd256();
        divisor  = 128'(rnd256());
      end
      @(posedge clk);
      lat++;
      #1;
      if (noise && !out_valid) check("in_ready_busy", 256'(in_ready), 256'(0));
      if (out_valid) break;
    end
    check("latency", 256'(lat), (b == '0) ? 256'(1) : 256'(256));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 256'(out_valid), 256'(1));
      if (noise) check("in_ready_done", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    exp_valid = 1'b0;
    check("post_hs_out_valid", 256'(out_valid), 256'(0));
    check("post_hs_in_ready", 256'(in_ready), 256'(1));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, 256'(in_ready), 256'(1));
    check({tag, "_out_valid"}, 256'(out_valid), 256'(0));
    check({tag, "_quotient"}, quotient, 256'(0));
    check({tag, "_remainder"}, 256'(remainder), 256'(0));
    check({tag, "_dbz"}, 256'(div_by_zero), 256'(0));
  endtask

  initial begin
    logic [255:0] big;
    logic [255:0] b256;
    logic [127:0] b;
    #12;
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    do_op(256'd1000, 128'd7, 0, 1'b0);
    check("lit_1000_7_q", quotient, 256'd142);
    check("lit_1000_7_r", 256'(remainder), 256'd6);

    do_op('1, 128'd1, 0, 1'b0);
    check("lit_max_1_q", quotient, '1);
    do_op('1, '1, 0, 1'b0);
    big = (256'd1 << 128) + 256'd1;
    check("lit_max_max_q", quotient, big);
    check("lit_max_max_r", 256'(remainder), 256'd0);

    do_op(256'd5, 128'd9, 0, 1'b0);
    check("lit_5_9_q", quotient, 256'd0);
    check("lit_5_9_r", 256'(remainder), 256'd5);

    b256 = (256'd1 << 127) + 256'd1;
    big  = (256'd1 << 120) + 256'd3;
    b256 = b256 * big + (256'd1 << 126);
    b    = (128'd1 << 127) + 128'd1;
    do_op(b256, b, 0, 1'b0);
    check("lit_big_q", quotient, big);
    check("lit_big_r", 256'(remainder), 256'(128'd1 << 126));

    do_op(256'h1234, 128'd0, 0, 1'b0);
    check("lit_dbz_flag", 256'(div_by_zero), 256'd1);
    check("lit_dbz_q", quotient, '1);
    check("lit_dbz_r", 256'(remainder), 256'h1234);
    do_op(256'd1000, 128'd7, 0, 1'b0);
    check("lit_after_dbz_flag", 256'(div_by_zero), 256'd0);

    do_op(rnd256(), 128'(rnd256()) >> 64, 10, 1'b1);
    do_op(rnd256(), 128'd0, 10, 1'b1);

    // Reset in the middle of a calculation.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 256'd1000;
    divisor  = 128'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (100) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midcalc_reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (300) begin
      @(negedge clk);
      if (out_valid) check("stale_after_reset", 256'(out_valid), 256'(0));
    end
    do_op(256'd1000, 128'd7, 0, 1'b0);
    check("lit_post_reset_q", quotient, 256'd142);

    for (int k = 0; k < 16; k++) begin
      logic [255:0] a;
      a = rnd256() >> $urandom_range(0, 255);
      case ($urandom_range(0, 3))
        0: b = 128'd0;
        1: b = 128'($urandom_range(1, 1000));
        2: b = 128'(rnd256()) >> $urandom_range(0, 127);
        default: b = 128'(rnd256()) | (128'd1 << 127);
      endcase
      do_op(a, b, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
